// File: rtl/button_led_ctrl.sv
// Debounced push-button front end driving an LED pattern register.
// Each active-low button is synchronised and debounced into a one-cycle press strobe.
module button_led_ctrl #(
  parameter int NUM_BTN        = 2,
  parameter int LED_WIDTH      = 3,
  parameter int DEBOUNCE       = 4,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   button,
  input  logic [1:0]           mode,
  output logic [NUM_BTN-1:0]   press,
  output logic [LED_WIDTH-1:0] led
);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam int TOG_N = (NUM_BTN < LED_WIDTH) ? NUM_BTN : LED_WIDTH;
  localparam logic [LED_WIDTH-1:0] ONE = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_XOR = LED_ACTIVE_LOW ? '1 : '0;

  logic [NUM_BTN-1:0]   sync1_q, sync2_q;
  logic [NUM_BTN-1:0]   stable_q, stable_d;
  logic [NUM_BTN-1:0]   stableDly_q;
  logic [NUM_BTN-1:0]   press_q, press_d;
  logic [CNT_W-1:0]     cnt_q [NUM_BTN];
  logic [CNT_W-1:0]     cnt_d [NUM_BTN];
  logic [LED_WIDTH-1:0] pattern_q, pattern_d;
  logic [LED_WIDTH-1:0] led_q;
  logic                 oneHot;
  mode_e                modeSel;

  // The window closes on the edge where the count would reach DEBOUNCE,
  // so stable flips and the counter clears in the same cycle.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < NUM_BTN; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign press_d = stableDly_q & ~stable_q;
  assign oneHot  = (pattern_q != '0) && ((pattern_q & (pattern_q - ONE)) == '0);
  assign modeSel = mode_e'(mode);

  always_comb begin
    pattern_d = pattern_q;
    case (modeSel)
      MODE_COUNT: begin
        if (press_q[0] && !press_q[1]) begin
          pattern_d = pattern_q + ONE;
        end else if (press_q[1] && !press_q[0]) begin
          pattern_d = pattern_q - ONE;
        end
      end
      MODE_ROTATE: begin
        // A corrupted (non one-hot) pattern is re-seeded rather than rotated.
        if (press_q[0] != press_q[1]) begin
          if (!oneHot) begin
            pattern_d = ONE;
          end else if (press_q[0]) begin
            pattern_d = {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]};
          end else begin
            pattern_d = {pattern_q[0], pattern_q[LED_WIDTH-1:1]};
          end
        end
      end
      MODE_TOGGLE: begin
        for (int k = 0; k < TOG_N; k++) begin
          if (press_q[k]) begin
            pattern_d[k] = ~pattern_q[k];
          end
        end
      end
      default: pattern_d = pattern_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      stable_q    <= '1;
      stableDly_q <= '1;
      press_q     <= '0;
      cnt_q       <= '{default: '0};
      pattern_q   <= '0;
      led_q       <= LED_XOR;
    end else begin
      sync1_q     <= button;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      led_q       <= pattern_d ^ LED_XOR;
    end
  end

  assign press = press_q;
  assign led   = led_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed self-checking bench for button_led_ctrl with default parameters
// (2 buttons, 3 LEDs, DEBOUNCE=4, active-low LEDs).
module tb_button_led_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] button = 2'b11;
  logic [1:0] mode = 2'b00;
  logic [1:0] press;
  logic [2:0] led;

  int checkCount = 0;
  int errorCount = 0;

  button_led_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .mode   (mode),
    .press  (press),
    .led    (led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Clean 5-cycle press started on a falling edge; checks strobe timing and resulting LEDs.
  task automatic applyStimulus(input string tag, input logic [1:0] mask, input logic [2:0] expLed);
    button = ~mask;
    repeat (5) @(negedge clk);
    button = 2'b11;
    @(negedge clk);
    checkOutput({tag, "_pre"}, 32'(press), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_strobe"}, 32'(press), 32'(mask));
    @(negedge clk);
    checkOutput({tag, "_post"}, 32'(press), 32'd0);
    checkOutput({tag, "_led"}, 32'(led), 32'(expLed));
    repeat (10) @(negedge clk);
  endtask

  task automatic countPulses(input int cycles, inout int n);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (press[0]) n++;
    end
  endtask

  // Button 0 held through reset: strobe after the 7th falling edge, LEDs after the 8th.
  task automatic checkAfterRelease(input string tag);
    repeat (6) @(negedge clk);
    checkOutput({tag, "_pre"}, 32'(press), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_strobe"}, 32'(press), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_led"}, 32'(led), 32'b110);
  endtask

  initial begin
    int n;
    logic [2:0] cntLeds [8];
    cntLeds = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000, 3'b111};

    #1 rst = 1'b1;
    #1;
    checkOutput("reset_led", 32'(led), 32'b111);
    checkOutput("reset_press", 32'(press), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_led", 32'(led), 32'b111);

    mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("count_up%0d", i), 2'b01, cntLeds[i]);
    end
    applyStimulus("count_down", 2'b10, 3'b000);

    n = 0;
    button = 2'b10;
    countPulses(3, n);
    button = 2'b11;
    countPulses(15, n);
    for (int i = 0; i < 10; i++) begin
      button[0] = ~button[0];
      countPulses(1, n);
    end
    button = 2'b11;
    countPulses(15, n);
    checkOutput("glitch_pulses", 32'(n), 32'd0);
    checkOutput("glitch_led", 32'(led), 32'b000);

    n = 0;
    button = 2'b10;
    countPulses(100, n);
    button = 2'b11;
    countPulses(15, n);
    checkOutput("hold_pulses", 32'(n), 32'd1);
    checkOutput("hold_led", 32'(led), 32'b111);

    mode = 2'b01;
    applyStimulus("rot_seed", 2'b01, 3'b110);
    applyStimulus("rot_l1", 2'b01, 3'b101);
    applyStimulus("rot_l2", 2'b01, 3'b011);
    applyStimulus("rot_l3", 2'b01, 3'b110);
    applyStimulus("rot_r", 2'b10, 3'b011);

    mode = 2'b00;
    applyStimulus("both_count", 2'b11, 3'b011);
    mode = 2'b10;
    applyStimulus("both_toggle", 2'b11, 3'b000);
    mode = 2'b11;
    applyStimulus("both_hold", 2'b11, 3'b000);
    mode = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("mode_change_led", 32'(led), 32'b000);

    button = 2'b10;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_debounce_led", 32'(led), 32'b111);
    checkOutput("rst_debounce_press", 32'(press), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkAfterRelease("rst_debounce_resume");
    button = 2'b11;
    repeat (15) @(negedge clk);

    button = 2'b10;
    repeat (7) @(negedge clk);
    checkOutput("rst_strobe_before", 32'(press), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_strobe_press", 32'(press), 32'd0);
    checkOutput("rst_strobe_led", 32'(led), 32'b111);
    @(negedge clk);
    rst = 1'b0;
    checkAfterRelease("rst_strobe_resume");
    button = 2'b11;
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
